// File: rtl/pc_stack.sv
// Program counter with absolute jump, signed relative branch and a return-address
// stack for call/return; overflow and underflow are reported as sticky flags.
module pc_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int OFFW = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [2:0]                   op,
   input  logic [WIDTH-1:0]             target,
   input  logic [OFFW-1:0]              offset,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             count,
   output logic [$clog2(DEPTH+1)-1:0]   ras_depth,
   output logic                         ras_full,
   output logic                         ras_empty,
   output logic                         ovf,
   output logic                         unf
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] OP_INC  = 3'd1;
   localparam logic [2:0] OP_JMP  = 3'd2;
   localparam logic [2:0] OP_BR   = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;

   logic [WIDTH-1:0] stack [DEPTH];
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] top;
   logic [PW-1:0]    wr_idx;
   logic [PW-1:0]    rd_idx;
   logic             do_push;
   logic             do_pop;
   logic             ovf_evt;
   logic             unf_evt;

   // Base of a branch is the current count; the offset is sign-extended to WIDTH.
   function automatic logic [WIDTH-1:0] branch_target(input logic [WIDTH-1:0] base,
                                                      input logic [OFFW-1:0] off);
      logic signed [OFFW-1:0]  soff;
      logic signed [WIDTH-1:0] ext;
      soff = off;
      ext  = WIDTH'(soff);
      return base + $unsigned(ext);
   endfunction

   assign ras_full  = (ras_depth == DW'(DEPTH));
   assign ras_empty = (ras_depth == '0);

   assign count_inc = count + WIDTH'(1);
   assign wr_idx    = PW'(ras_depth);
   assign rd_idx    = PW'(ras_depth - DW'(1));
   assign top       = stack[rd_idx];

   assign do_push = (op == OP_CALL) && !ras_full;
   assign do_pop  = (op == OP_RET) && !ras_empty;
   assign ovf_evt = (op == OP_CALL) && ras_full;
   assign unf_evt = (op == OP_RET) && ras_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= RESET_VEC;
         ras_depth <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else begin
         case (op)
            OP_INC:  count <= count_inc;
            OP_JMP:  count <= target;
            OP_BR:   count <= branch_target(count, offset);
            OP_CALL: begin
               if (do_push) begin
                  count     <= target;
                  ras_depth <= ras_depth + DW'(1);
               end
            end
            OP_RET: begin
               if (do_pop) begin
                  count     <= top;
                  ras_depth <= ras_depth - DW'(1);
               end
            end
            default: ;
         endcase
         // A new error on the same edge as clr_err leaves the flag set.
         ovf <= (ovf & ~clr_err) | ovf_evt;
         unf <= (unf & ~clr_err) | unf_evt;
      end
   end

   // Stack storage is data only and carries no reset.
   always_ff @(posedge clk) begin
      if (do_push && reset) stack[wr_idx] <= count_inc;
   end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: a queue-based model is compared every cycle,
// plus literal expectations at key points of each scenario.
module tb_pc_stack;

   localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JMP = 3'd2, BR = 3'd3,
                          CALL = 3'd4, RET = 3'd5;

   logic       clk;
   logic       reset;
   logic [2:0] op;
   logic [7:0] target;
   logic [7:0] offset;
   logic       clr_err;
   logic [7:0] count;
   logic [2:0] ras_depth;
   logic       ras_full, ras_empty, ovf, unf;

   pc_stack #(.WIDTH(8), .DEPTH(4), .OFFW(8), .RESET_VEC(8'h00)) dut (
      .clk(clk), .reset(reset), .op(op), .target(target), .offset(offset),
      .clr_err(clr_err), .count(count), .ras_depth(ras_depth),
      .ras_full(ras_full), .ras_empty(ras_empty), .ovf(ovf), .unf(unf)
   );

   int total = 0;
   int bad = 0;
   logic chk_en = 1'b0;

   logic [7:0] m_count;
   logic [7:0] m_stk[$];
   logic       m_ovf, m_unf;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", int'(count), int'(m_count));
         chk("depth", int'(ras_depth), m_stk.size());
         chk("full", int'(ras_full), int'(m_stk.size() == 4));
         chk("empty", int'(ras_empty), int'(m_stk.size() == 0));
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("unf", int'(unf), int'(m_unf));
      end
   end

   task automatic model_reset();
      m_count = 8'h00;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic step(input logic [2:0] o, input logic [7:0] t, input logic [7:0] off,
                       input logic c);
      int s;
      logic oe, ue;
      op = o; target = t; offset = off; clr_err = c;
      @(posedge clk);
      oe = 1'b0; ue = 1'b0;
      case (o)
         INC: m_count = m_count + 8'd1;
         JMP: m_count = t;
         BR: begin
            s = $signed(off);
            m_count = 8'(int'(m_count) + s);
         end
         CALL: begin
            if (m_stk.size() < 4) begin
               m_stk.push_back(m_count + 8'd1);
               m_count = t;
            end else oe = 1'b1;
         end
         RET: begin
            if (m_stk.size() > 0) m_count = m_stk.pop_back();
            else ue = 1'b1;
         end
         default: ;
      endcase
      m_ovf = (m_ovf && !c) || oe;
      m_unf = (m_unf && !c) || ue;
      #1;
      op = HOLD; clr_err = 1'b0;
   endtask

   initial begin
      op = HOLD; target = '0; offset = '0; clr_err = 1'b0;
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      chk("rst_count", int'(count), 0);
      chk("rst_depth", int'(ras_depth), 0);
      chk("rst_flags", int'({ovf, unf}), 0);
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b1;

      // Reset / INC, with an asynchronous reset at count 0x0A
      for (int i = 0; i < 10; i++) step(INC, 8'h00, 8'h00, 1'b0);
      chk("inc10", int'(count), 8'h0A);
      #2 reset = 1'b0;
      model_reset();
      #1 chk("async_rst", int'(count), 0);
      @(posedge clk); @(posedge clk);
      #1 chk("rst_hold", int'(count), 0);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) step(INC, 8'h00, 8'h00, 1'b0);
      chk("inc20", int'(count), 8'h14);

      // Wrap
      step(JMP, 8'hFE, 8'h00, 1'b0); chk("jmp_fe", int'(count), 8'hFE);
      step(INC, 8'h00, 8'h00, 1'b0); chk("wrap_ff", int'(count), 8'hFF);
      step(INC, 8'h00, 8'h00, 1'b0); chk("wrap_00", int'(count), 8'h00);
      step(INC, 8'h00, 8'h00, 1'b0);
      step(HOLD, 8'h55, 8'h00, 1'b0);
      step(HOLD, 8'h55, 8'h00, 1'b0); chk("hold", int'(count), 8'h01);

      // Branch
      step(JMP, 8'h10, 8'h00, 1'b0);
      step(BR, 8'h00, 8'hFC, 1'b0); chk("br_neg", int'(count), 8'h0C);
      step(JMP, 8'hFD, 8'h00, 1'b0);
      step(BR, 8'h00, 8'h05, 1'b0); chk("br_wrap", int'(count), 8'h02);

      // Nested call
      step(JMP, 8'h05, 8'h00, 1'b0);
      step(CALL, 8'h40, 8'h00, 1'b0); chk("call1", int'(count), 8'h40);
      step(INC, 8'h00, 8'h00, 1'b0);
      step(CALL, 8'h80, 8'h00, 1'b0); chk("call2_depth", int'(ras_depth), 2);
      step(RET, 8'h00, 8'h00, 1'b0); chk("ret1", int'(count), 8'h42);
      step(RET, 8'h00, 8'h00, 1'b0); chk("ret2", int'(count), 8'h06);
      chk("ret2_empty", int'(ras_empty), 1);

      // Overflow
      step(JMP, 8'h07, 8'h00, 1'b0);
      step(CALL, 8'h10, 8'h00, 1'b0);
      step(CALL, 8'h20, 8'h00, 1'b0);
      step(CALL, 8'h30, 8'h00, 1'b0);
      step(CALL, 8'h40, 8'h00, 1'b0); chk("full4", int'(ras_full), 1);
      step(CALL, 8'h99, 8'h00, 1'b0); chk("ovf_count", int'(count), 8'h40);
      chk("ovf_set", int'(ovf), 1);
      step(CALL, 8'h99, 8'h00, 1'b1); chk("ovf_clr_same", int'(ovf), 1);
      step(RET, 8'h00, 8'h00, 1'b0); chk("oret1", int'(count), 8'h31);
      step(RET, 8'h00, 8'h00, 1'b0); chk("oret2", int'(count), 8'h21);
      step(RET, 8'h00, 8'h00, 1'b0); chk("oret3", int'(count), 8'h11);
      step(RET, 8'h00, 8'h00, 1'b0); chk("oret4", int'(count), 8'h08);
      step(HOLD, 8'h00, 8'h00, 1'b1); chk("ovf_clr", int'(ovf), 0);

      // Underflow and undefined ops
      step(JMP, 8'h22, 8'h00, 1'b0);
      step(3'd6, 8'h77, 8'h00, 1'b0);
      step(3'd7, 8'h77, 8'h00, 1'b0); chk("undef_op", int'(count), 8'h22);
      chk("undef_flags", int'({ovf, unf}), 0);
      step(RET, 8'h00, 8'h00, 1'b0); chk("unf_count", int'(count), 8'h22);
      chk("unf_set", int'(unf), 1);
      step(RET, 8'h00, 8'h00, 1'b1); chk("unf_clr_same", int'(unf), 1);
      step(HOLD, 8'h00, 8'h00, 1'b1); chk("unf_clr", int'(unf), 0);
      chk("unf_ovf", int'(ovf), 0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with absolute jump, signed relative branch, and a hardware return-address stack for call/return. It is the successor to the 8-bit free-running counter. It drives the instruction ROM address in the pc_rom datapath. Each cycle the counter executes one operation from a 3-bit command. Stack overflow and underflow are reported as sticky error flags.

## Interface
- WIDTH, 8, counter and address width in bits (≥2)
- DEPTH, 4, return-stack entries (≥1)
- OFFW, 8, branch offset width in bits, two's complement (1 ≤ OFFW ≤ WIDTH)
- RESET_VEC, 0, count value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset input; one clock, reset asynchronous and active-low
- op  in  3  command: 0 HOLD, 1 INC, 2 JMP, 3 BR, 4 CALL, 5 RET, 6/7 treated as HOLD
- target  in  WIDTH  absolute destination for JMP and CALL
- offset  in  OFFW  signed displacement for BR
- clr_err  in  1  clears ovf/unf
- count  out  WIDTH  current program counter
- ras_depth  out  $clog2(DEPTH+1)  number of valid stack entries
- ras_full  out  1  ras_depth == DEPTH
- ras_empty  out  1  ras_depth == 0
- ovf  out  1  sticky: CALL attempted while full
- unf  out  1  sticky: RET attempted while empty

## Operation
- Reset asserted (reset=0), asynchronously: count=RESET_VEC, ras_depth=0, ovf=0, unf=0. Outputs hold these values while reset is low. Stack RAM contents are don't-care.
- HOLD: no state change.
- INC: count ← count+1 mod 2^WIDTH. 2^WIDTH−1 wraps to 0.
- JMP: count ← target.
- BR: count ← count + sign_extend(offset) mod 2^WIDTH. The base is the current count, not count+1.
- CALL, not full: push (count+1 mod 2^WIDTH), count ← target, ras_depth+1.
- CALL, full: count, stack and ras_depth unchanged; ovf ← 1. No entry is overwritten or discarded.
- RET, not empty: count ← top entry, ras_depth−1.
- RET, empty: count and ras_depth unchanged; unf ← 1.
- Stack is LIFO. Entries above ras_depth are never read.
- clr_err=1 clears ovf and unf at the edge. If a new error occurs on the same edge, the error wins and the flag is 1 afterwards. clr_err does not affect count or the stack.
- op values are sampled only at rising edges with reset high. Undefined op (6, 7) behaves as HOLD and sets no flags.

## Timing
- All state is registered. The op effect is visible on count/ras_depth/flags immediately after the sampling edge: 1-cycle latency, one op per cycle, no stalls, no backpressure.
- ras_full and ras_empty are combinational decodes of registered ras_depth. They have no extra latency and no glitches from inputs.
- Back-to-back CALL/RET are legal. A RET on the edge after a CALL returns the address pushed by that CALL.
- Reset deassertion is synchronised by the system. The first op is sampled on the first rising edge after reset goes high.
- Reset mid-sequence (any depth, any flags) restores all reset values asynchronously, without waiting for clk.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, OFFW=8, RESET_VEC=0.
- **Reset/INC:** reset low, then high, then INC for 20 cycles → count 0x00…0x14. Pull reset low mid-edge-gap at count 0x0A → count 0x00 before the next clk edge; count holds 0x00 while low.
- **Wrap:** JMP 0xFE, then INC ×3 → count 0xFE, 0xFF, 0x00, 0x01. HOLD ×2 → count stays 0x01.
- **Branch:** JMP 0x10, BR offset 0xFC → 0x0C. JMP 0xFD, BR offset 0x05 → 0x02 (wrap).
- **Nested call:**
  - At count 0x05, CALL 0x40 → count 0x40, depth 1.
  - INC → 0x41.
  - CALL 0x80 → count 0x80, depth 2.
  - RET → 0x42, depth 1.
  - RET → 0x06, depth 0, ras_empty=1.
- **Overflow:**
  - CALL 0x10, 0x20, 0x30, 0x40 → depth 4, ras_full=1, count 0x40.
  - CALL 0x99 → count 0x40, depth 4, ovf=1.
  - RET ×4 → 0x31, 0x21, 0x11, then original count+1.
  - clr_err → ovf=0.
- **Underflow:**
  - RET with depth 0 and count 0x22 → count 0x22, unf=1.
  - clr_err together with another empty RET → unf stays 1.
  - clr_err alone → unf=0; ovf is unaffected throughout.
